// File: rtl/edge_sched_pkg.sv
// Shared types and helpers for the edge event scheduler: widths, FSM encoding
// and the round-robin picker.
package edge_sched_pkg;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    OFFER  = 2'd2
  } state_t;

  // Returns {found, index}. Scanning from the top offset down lets the lowest
  // offset from ptr overwrite, so the first set bit at/after ptr wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [WIDTH-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   res;
    res = {(IDX_W+1){1'b0}};
    for (int k = WIDTH-1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      res = req[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

endpackage

// File: rtl/edge_sampler_16bit.sv
// Two-stage enabled sampler: s1 takes d and s2 takes s1 on each enable.
module edge_sampler_16bit
  import edge_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2
);

  // Sample stages
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= {WIDTH{1'b0}};
      s2 <= {WIDTH{1'b0}};
    end else if (en) begin
      s1 <= d;
      s2 <= s1;
    end
  end

endmodule

// File: rtl/edge_event_scheduler.sv
// Periodic sampler control, edge-to-pending capture and round-robin
// serialization of pending edges over a valid/ready port.
module edge_event_scheduler
  import edge_sched_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] mask,
  input  logic             clear_ovf,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IDX_W-1:0] ev_index,
  output logic             ev_rise,
  output logic [WIDTH-1:0] pending,
  output logic             overflow
);

  localparam logic [15:0] CNT_MAX = 16'(TICK_DIV - 1);

  logic [15:0]      cnt_r;
  logic             sample_en_s;
  logic             upd_r;
  logic             primed_r;
  logic [WIDTH-1:0] s1_s;
  logic [WIDTH-1:0] s2_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] live_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] pending_r;
  logic [WIDTH-1:0] dir_r;
  logic             overflow_r;
  logic [IDX_W:0]   pick_s;
  logic [IDX_W-1:0] pick_idx_s;
  state_t           state_r;
  state_t           state_nxt;
  logic             ev_valid_r;
  logic [IDX_W-1:0] ev_index_r;
  logic [IDX_W-1:0] idx_nxt;
  logic             ev_rise_r;
  logic             rise_nxt;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] rr_nxt;

  assign sample_en_s = (cnt_r == CNT_MAX);

  // Prescaler, sample-update strobe and priming
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= 16'd0;
      upd_r    <= 1'b0;
      primed_r <= 1'b0;
    end else begin
      cnt_r    <= sample_en_s ? 16'd0 : cnt_r + 16'd1;
      upd_r    <= sample_en_s;
      // The first update after reset compares against the zeroed s2, so it
      // only arms the capture instead of producing edges.
      primed_r <= primed_r | upd_r;
    end
  end

  edge_sampler_16bit u_sampler (
    .clk   (clk),
    .reset (reset),
    .en    (sample_en_s),
    .d     (d),
    .s1    (s1_s),
    .s2    (s2_s)
  );

  assign edge_s     = (upd_r && primed_r) ? ((s1_s ^ s2_s) & mask) : {WIDTH{1'b0}};
  assign live_s     = pending_r & mask;
  assign pick_s     = rr_pick(live_s, rr_ptr_r);
  assign pick_idx_s = pick_s[IDX_W-1:0];

  // Pending flags, edge direction and sticky overflow; a fresh edge beats a
  // same-cycle grant clear and is not counted as an overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r  <= {WIDTH{1'b0}};
      dir_r      <= {WIDTH{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      pending_r <= ((pending_r & ~clr_s) | edge_s) & mask;
      dir_r     <= (dir_r & ~edge_s) | (s1_s & edge_s);
      if (|(edge_s & pending_r & ~clr_s)) begin
        overflow_r <= 1'b1;
      end else if (clear_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // FSM next state, grant selection and handshake bookkeeping
  always_comb begin
    state_nxt = state_r;
    idx_nxt   = ev_index_r;
    rise_nxt  = ev_rise_r;
    rr_nxt    = rr_ptr_r;
    clr_s     = {WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (|live_s) begin
          state_nxt = SELECT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SELECT: begin
        if (pick_s[IDX_W]) begin
          idx_nxt   = pick_idx_s;
          rise_nxt  = dir_r[pick_idx_s];
          clr_s     = {{(WIDTH-1){1'b0}}, 1'b1} << pick_idx_s;
          state_nxt = OFFER;
        end else begin
          state_nxt = IDLE;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          rr_nxt = ev_index_r + 4'd1;
          if (|live_s) begin
            state_nxt = SELECT;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = OFFER;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and registered offer outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      ev_valid_r <= 1'b0;
      ev_index_r <= {IDX_W{1'b0}};
      ev_rise_r  <= 1'b0;
      rr_ptr_r   <= {IDX_W{1'b0}};
    end else begin
      state_r    <= state_nxt;
      ev_valid_r <= (state_nxt == OFFER);
      ev_index_r <= idx_nxt;
      ev_rise_r  <= rise_nxt;
      rr_ptr_r   <= rr_nxt;
    end
  end

  assign ev_valid = ev_valid_r;
  assign ev_index = ev_index_r;
  assign ev_rise  = ev_rise_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed and randomized bench for edge_event_scheduler with a transaction-level
// reference model (edge sets expanded into round-robin event order).
module tb_edge_event_scheduler;

  localparam int TD = 4;

  typedef struct {
    int   idx;
    logic rise;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] d;
  logic [15:0] mask;
  logic        clear_ovf;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_index;
  logic        ev_rise;
  logic [15:0] pending;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int ks;
  logic [15:0] d_m;
  int   rr_m;
  ev_t  exp_q[$];
  int   got_idx[$];
  int   got_t[$];
  logic seen;

  edge_event_scheduler #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .reset     (reset),
    .d         (d),
    .mask      (mask),
    .clear_ovf (clear_ovf),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_index  (ev_index),
    .ev_rise   (ev_rise),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; a sample is captured on every 4th one.
  always @(posedge clk) begin
    if (reset) ks <= 0;
    else       ks <= ks + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected events for a set of simultaneous edges: rotation order from rr_m.
  task automatic plan(input logic [15:0] e, input logic [15:0] v);
    int i;
    for (int k = 0; k < 16; k++) begin
      i = (rr_m + k) % 16;
      if (e[i]) exp_q.push_back('{i, v[i]});
    end
  endtask

  // Called at a negedge. Drives ready, scores handshakes, checks hold stability.
  task automatic drain(input int pct, input int ncyc);
    logic       held;
    logic [3:0] h_idx;
    logic       h_rise;
    ev_t        e;
    held = 1'b0;
    got_idx.delete();
    got_t.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (held) begin
        chk("hold_valid", 16'(ev_valid), 16'd1);
        chk("hold_index", 16'(ev_index), 16'(h_idx));
        chk("hold_rise", 16'(ev_rise), 16'(h_rise));
      end
      held = 1'b0;
      ev_ready = ($urandom_range(99) < pct);
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL unexpected_event: observed index %0d expected none", ev_index);
        end else begin
          e = exp_q.pop_front();
          chk("ev_index", 16'(ev_index), 16'(e.idx));
          chk("ev_rise", 16'(ev_rise), 16'(e.rise));
          rr_m = (e.idx + 1) % 16;
          got_idx.push_back(e.idx);
          got_t.push_back(ks);
        end
      end else if (ev_valid) begin
        held   = 1'b1;
        h_idx  = ev_index;
        h_rise = ev_rise;
      end
      @(negedge clk);
    end
    chk("drain_left", 16'(exp_q.size()), 16'd0);
    chk("drain_pending", pending, 16'h0000);
    chk("drain_valid", 16'(ev_valid), 16'd0);
    chk("drain_overflow", 16'(overflow), 16'd0);
    exp_q.delete();
  endtask

  task automatic step(input logic [15:0] nd, input int pct, input int ncyc);
    plan((nd ^ d_m) & mask, nd);
    d   = nd;
    d_m = nd;
    drain(pct, ncyc);
  endtask

  task automatic wait_valid(input string tag);
    int c;
    c = 0;
    while (!ev_valid && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 16'(ev_valid), 16'd1);
  endtask

  task automatic quiet(input string tag, input int ncyc);
    seen = 1'b0;
    repeat (ncyc) begin
      @(negedge clk);
      seen = seen | ev_valid | (|pending);
    end
    chk(tag, 16'(seen), 16'd0);
  endtask

  initial begin
    reset     = 1'b1;
    d         = 16'h0005;
    mask      = 16'hFFFF;
    clear_ovf = 1'b0;
    ev_ready  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_valid", 16'(ev_valid), 16'd0);
    chk("rst_index", 16'(ev_index), 16'd0);
    chk("rst_rise", 16'(ev_rise), 16'd0);
    chk("rst_pending", pending, 16'h0000);
    chk("rst_overflow", 16'(overflow), 16'd0);

    // Priming: constant d over three samples yields nothing
    quiet("prime_quiet", 12);
    d_m  = 16'h0005;
    rr_m = 0;

    // Latency: capture in cycle n, pending at n+2, ev_valid at n+4
    while (ks % 4 != 3) @(negedge clk);
    d   = 16'h0004;
    d_m = 16'h0004;
    repeat (2) @(negedge clk);
    chk("lat_pending_n2", pending, 16'h0001);
    chk("lat_valid_n2", 16'(ev_valid), 16'd0);
    @(negedge clk);
    chk("lat_valid_n3", 16'(ev_valid), 16'd0);
    @(negedge clk);
    chk("lat_valid_n4", 16'(ev_valid), 16'd1);
    chk("lat_index", 16'(ev_index), 16'd0);
    chk("lat_rise", 16'(ev_rise), 16'd0);
    exp_q.push_back('{0, 1'b0});
    drain(100, 20);

    // Round-robin: 3, 7, 12 rising together, 2 cycles apart
    step(16'h108C, 100, 40);
    chk("rr_a0", 16'(got_idx[0]), 16'd3);
    chk("rr_a1", 16'(got_idx[1]), 16'd7);
    chk("rr_a2", 16'(got_idx[2]), 16'd12);
    chk("rr_gap01", 16'(got_t[1] - got_t[0]), 16'd2);
    chk("rr_gap12", 16'(got_t[2] - got_t[1]), 16'd2);
    step(16'h0084, 100, 40);
    chk("rr_b0", 16'(got_idx[0]), 16'd3);
    chk("rr_b1", 16'(got_idx[1]), 16'd12);
    step(16'h0004, 100, 40);
    step(16'h100C, 100, 40);
    chk("rr_c0", 16'(got_idx[0]), 16'd12);
    chk("rr_c1", 16'(got_idx[1]), 16'd3);

    // Backpressure with overflow on bit 5, then masking of bit 9
    ev_ready = 1'b0;
    d = d_m ^ 16'h0002;
    wait_valid("bp_valid");
    chk("bp_index", 16'(ev_index), 16'd1);
    chk("bp_rise", 16'(ev_rise), 16'd1);
    for (int c = 0; c < 20; c++) begin
      if (c == 0 || c == 8) d = d ^ 16'h0020;
      @(negedge clk);
      chk("bp_hold_valid", 16'(ev_valid), 16'd1);
      chk("bp_hold_index", 16'(ev_index), 16'd1);
      chk("bp_hold_rise", 16'(ev_rise), 16'd1);
    end
    chk("bp_overflow", 16'(overflow), 16'd1);
    chk("bp_pending5", 16'(pending[5]), 16'd1);
    d = d ^ 16'h0200;
    repeat (8) @(negedge clk);
    chk("mask_pend9_set", 16'(pending[9]), 16'd1);
    mask = 16'hFDFF;
    @(negedge clk);
    chk("mask_pend9_drop", 16'(pending[9]), 16'd0);
    d = d ^ 16'h0200;
    repeat (12) @(negedge clk);
    chk("mask_pend9_ignored", 16'(pending[9]), 16'd0);
    mask = 16'hFFFF;
    @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("clear_ovf", 16'(overflow), 16'd0);
    d_m = d;
    exp_q.push_back('{1, 1'b1});
    exp_q.push_back('{5, 1'b0});
    drain(100, 30);

    // Same-cycle grant and new edge on bit 2
    ev_ready = 1'b0;
    d = d_m ^ 16'h0002;
    wait_valid("sim_valid");
    chk("sim_index1", 16'(ev_index), 16'd1);
    d = d ^ 16'h0004;
    repeat (8) @(negedge clk);
    chk("sim_pend2", 16'(pending[2]), 16'd1);
    while (ks % 4 != 3) @(negedge clk);
    d = d ^ 16'h0004;
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    @(negedge clk);
    chk("sim_offer_valid", 16'(ev_valid), 16'd1);
    chk("sim_offer_index", 16'(ev_index), 16'd2);
    chk("sim_offer_rise", 16'(ev_rise), 16'd0);
    chk("sim_pend2_kept", 16'(pending[2]), 16'd1);
    chk("sim_no_overflow", 16'(overflow), 16'd0);
    d_m  = d;
    rr_m = 2;
    exp_q.push_back('{2, 1'b0});
    exp_q.push_back('{2, 1'b1});
    drain(100, 20);

    // Reset while offering
    ev_ready = 1'b0;
    d = d_m ^ 16'h8000;
    wait_valid("rst_mid_valid");
    d = d ^ 16'h0020;
    repeat (8) @(negedge clk);
    d = d ^ 16'h0020;
    repeat (8) @(negedge clk);
    chk("rst_mid_ovf_pre", 16'(overflow), 16'd1);
    reset = 1'b1;
    ev_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_valid0", 16'(ev_valid), 16'd0);
    chk("rst_mid_pending0", pending, 16'h0000);
    chk("rst_mid_ovf0", 16'(overflow), 16'd0);
    quiet("rst_mid_quiet", 12);
    d_m  = d;
    rr_m = 0;
    step(d ^ 16'h8001, 100, 40);
    chk("rst_rr0", 16'(got_idx[0]), 16'd0);
    chk("rst_rr1", 16'(got_idx[1]), 16'd15);

    // Randomized edge sets, masks and backpressure against the model
    for (int it = 0; it < 24; it++) begin
      mask = ($urandom_range(3) == 0) ? 16'($urandom) : 16'hFFFF;
      step(16'($urandom), $urandom_range(100, 30), 160);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
